// File: rtl/data_table_delete_v2_pkg.sv
// data_table_delete_v2_pkg: hash-table types shared by the delete engine and its neighbours
package data_table_delete_v2_pkg;
    localparam int TABLE_ADDR_WIDTH = 8;
    localparam int KEY_WIDTH = 16;
    localparam int VALUE_WIDTH = 16;
    localparam int BUCKET_WIDTH = 8;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VALUE_WIDTH-1:0] value;
    } ht_command_t;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VALUE_WIDTH-1:0] value;
        logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
        logic next_ptr_val;
    } ram_data_t;

    typedef struct packed {
        ht_command_t cmd;
        logic [BUCKET_WIDTH-1:0] bucket;
        logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
        logic head_ptr_val;
    } ht_pdata_t;

    typedef enum logic [1:0] {
        DELETE_SUCCESS,
        DELETE_NOT_SUCCESS_NO_ENTRY,
        DELETE_NOT_SUCCESS_CHAIN_ERR
    } ht_rescode_t;

    typedef struct packed {
        ht_command_t cmd;
        ht_rescode_t rescode;
        logic [BUCKET_WIDTH-1:0] bucket;
        logic [VALUE_WIDTH-1:0] found_value;
    } ht_result_t;

    function automatic logic key_match(input ram_data_t rd, input ht_command_t c, input logic mv);
        return (rd.key == c.key) && (!mv || rd.value == c.value);
    endfunction
endpackage

// File: rtl/data_table_delete_v2_if.sv
// data_table_delete_v2_if: bucket head-table write port
interface data_table_delete_v2_if
    import data_table_delete_v2_pkg::*;
#(
    parameter int A_WIDTH = TABLE_ADDR_WIDTH
);
    logic [BUCKET_WIDTH-1:0] wr_addr;
    logic [A_WIDTH-1:0] wr_data_ptr;
    logic wr_data_ptr_val;
    logic wr_en;

    modport master (output wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en);
    modport slave (input wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en);
endinterface

// File: rtl/data_table_delete_v2_rd_data_val_helper.sv
// data_table_delete_v2_rd_data_val_helper: delays the read strobe by the RAM read latency
module data_table_delete_v2_rd_data_val_helper #(
    parameter int RAM_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rd_en_i,
    output logic rd_data_val_o
);
    logic [RAM_LATENCY-1:0] sr;

    generate
        if (RAM_LATENCY == 1) begin : g_one
            always_ff @(posedge clk_i or posedge rst_i)
                if (rst_i) sr <= '0;
                else sr <= rd_en_i;
        end else begin : g_many
            always_ff @(posedge clk_i or posedge rst_i)
                if (rst_i) sr <= '0;
                else sr <= {sr[RAM_LATENCY-2:0], rd_en_i};
        end
    endgenerate

    assign rd_data_val_o = sr[RAM_LATENCY-1];
endmodule

// File: rtl/data_table_delete_v2.sv
// data_table_delete_v2: walks a bucket chain, unlinks and clears the matching node, frees its address
module data_table_delete_v2
    import data_table_delete_v2_pkg::*;
#(
    parameter int RAM_LATENCY = 2,
    parameter int A_WIDTH = TABLE_ADDR_WIDTH,
    parameter bit MATCH_VALUE = 1'b0,
    parameter int MAX_CHAIN = 2 ** A_WIDTH
) (
    input  logic clk_i,
    input  logic rst_i,
    input  ht_pdata_t task_i,
    input  logic task_valid_i,
    output logic task_ready_o,
    input  ram_data_t rd_data_i,
    output logic [A_WIDTH-1:0] rd_addr_o,
    output logic rd_en_o,
    output logic [A_WIDTH-1:0] wr_addr_o,
    output ram_data_t wr_data_o,
    output logic wr_en_o,
    output logic [A_WIDTH-1:0] add_empty_ptr_o,
    output logic add_empty_ptr_en_o,
    data_table_delete_v2_if.master head_table_if,
    output ht_result_t result_o,
    output logic result_valid_o,
    input  logic result_ready_i
);
    localparam int CW = $clog2(MAX_CHAIN + 1);

    localparam logic [2:0] IDLE_S        = 3'd0;
    localparam logic [2:0] READ_S        = 3'd1;
    localparam logic [2:0] UNLINK_HEAD_S = 3'd2;
    localparam logic [2:0] UNLINK_PREV_S = 3'd3;
    localparam logic [2:0] CLEAR_S       = 3'd4;
    localparam logic [2:0] NO_ENTRY_S    = 3'd5;
    localparam logic [2:0] CHAIN_ERR_S   = 3'd6;
    localparam logic [2:0] REPORT_S      = 3'd7;

    logic [2:0] state;
    ht_command_t cmd;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic [A_WIDTH-1:0] cur_addr;
    logic [A_WIDTH-1:0] prev_addr;
    ht_command_t prev_kv;
    logic [TABLE_ADDR_WIDTH-1:0] cur_next_ptr;
    logic cur_next_val;
    logic is_head;
    logic issued;
    logic [CW-1:0] cnt;
    logic rd_val;
    logic hit;

    data_table_delete_v2_rd_data_val_helper #(
        .RAM_LATENCY(RAM_LATENCY)
    ) u_rd_val (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .rd_en_i(rd_en_o),
        .rd_data_val_o(rd_val)
    );

    assign hit = key_match(rd_data_i, cmd, MATCH_VALUE);

    // prev_kv keeps everything of the previous word except its link, which an unlink replaces
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state <= IDLE_S;
            cmd <= '0;
            bucket <= '0;
            cur_addr <= '0;
            prev_addr <= '0;
            prev_kv <= '0;
            cur_next_ptr <= '0;
            cur_next_val <= 1'b0;
            is_head <= 1'b0;
            issued <= 1'b0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE_S: if (task_valid_i) begin
                    cmd <= task_i.cmd;
                    bucket <= task_i.bucket;
                    cur_addr <= A_WIDTH'(task_i.head_ptr);
                    is_head <= 1'b1;
                    issued <= 1'b0;
                    cnt <= '0;
                    state <= task_i.head_ptr_val ? READ_S : NO_ENTRY_S;
                end
                READ_S: begin
                    issued <= 1'b1;
                    if (rd_val) begin
                        cur_next_ptr <= rd_data_i.next_ptr;
                        cur_next_val <= rd_data_i.next_ptr_val;
                        if (hit) state <= is_head ? UNLINK_HEAD_S : UNLINK_PREV_S;
                        else if (!rd_data_i.next_ptr_val) state <= NO_ENTRY_S;
                        else if (cnt + CW'(1) == CW'(MAX_CHAIN)) state <= CHAIN_ERR_S;
                        else begin
                            prev_addr <= cur_addr;
                            prev_kv <= '{key: rd_data_i.key, value: rd_data_i.value};
                            cur_addr <= A_WIDTH'(rd_data_i.next_ptr);
                            is_head <= 1'b0;
                            cnt <= cnt + CW'(1);
                            issued <= 1'b0;
                        end
                    end
                end
                UNLINK_HEAD_S, UNLINK_PREV_S: state <= CLEAR_S;
                CLEAR_S: state <= REPORT_S;
                default: if (result_ready_i) state <= IDLE_S;
            endcase
        end

    assign task_ready_o = state == IDLE_S;
    assign rd_en_o = state == READ_S && !issued;
    assign rd_addr_o = cur_addr;

    assign wr_en_o = state == UNLINK_PREV_S || state == CLEAR_S;
    assign wr_addr_o = state == UNLINK_PREV_S ? prev_addr : cur_addr;
    assign wr_data_o = state == UNLINK_PREV_S
        ? '{key: prev_kv.key, value: prev_kv.value, next_ptr: cur_next_ptr, next_ptr_val: cur_next_val}
        : '0;

    assign add_empty_ptr_en_o = state == CLEAR_S;
    assign add_empty_ptr_o = cur_addr;

    assign head_table_if.wr_en = state == UNLINK_HEAD_S;
    assign head_table_if.wr_addr = bucket;
    assign head_table_if.wr_data_ptr = A_WIDTH'(cur_next_ptr);
    assign head_table_if.wr_data_ptr_val = cur_next_val;

    assign result_valid_o = state == REPORT_S || state == NO_ENTRY_S || state == CHAIN_ERR_S;
    assign result_o = '{
        cmd: cmd,
        rescode: state == NO_ENTRY_S ? DELETE_NOT_SUCCESS_NO_ENTRY
               : state == CHAIN_ERR_S ? DELETE_NOT_SUCCESS_CHAIN_ERR : DELETE_SUCCESS,
        bucket: bucket,
        found_value: '0
    };
endmodule

// File: tb/tb_data_table_delete_v2.sv
// tb_data_table_delete_v2: directed vectors against three engine configurations sharing one RAM model
module tb_data_table_delete_v2;
    import data_table_delete_v2_pkg::*;

    typedef struct {
        int sel;
        int kind;
        logic [15:0] key;
        logic [15:0] value;
        logic [7:0] head;
        logic hval;
        int hold;
        ht_rescode_t code;
        int reads;
        int lat;
        logic hw;
        logic [7:0] hptr;
        logic hpval;
        int emp;
        ram_data_t m5;
        ram_data_t m9;
        ram_data_t m3;
    } vec_t;

    localparam ram_data_t N5  = '{key: 16'h0105, value: 16'h5005, next_ptr: 8'd9, next_ptr_val: 1'b1};
    localparam ram_data_t N9  = '{key: 16'h0109, value: 16'h5009, next_ptr: 8'd3, next_ptr_val: 1'b1};
    localparam ram_data_t N3  = '{key: 16'h0103, value: 16'h5003, next_ptr: 8'd0, next_ptr_val: 1'b0};
    localparam ram_data_t N53 = '{key: 16'h0105, value: 16'h5005, next_ptr: 8'd3, next_ptr_val: 1'b1};
    localparam ram_data_t N9T = '{key: 16'h0109, value: 16'h5009, next_ptr: 8'd0, next_ptr_val: 1'b0};
    localparam ram_data_t N4  = '{key: 16'h0404, value: 16'h4004, next_ptr: 8'd7, next_ptr_val: 1'b1};
    localparam ram_data_t N7  = '{key: 16'h0707, value: 16'h7007, next_ptr: 8'd4, next_ptr_val: 1'b1};
    localparam ram_data_t RZ  = '0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tv = 1'b0;
    logic rr = 1'b0;
    logic [1:0] sel = 2'd0;
    ht_pdata_t tsk = '0;
    ram_data_t rdata;
    logic bd_en = 1'b0;
    logic [7:0] bd_addr = '0;
    ram_data_t bd_data = '0;
    ram_data_t mem [256];
    logic [7:0] pa [3];
    int rd_cnt = 0, wr_cnt = 0, h_cnt = 0, e_cnt = 0, viol = 0;
    logic [7:0] lh_addr, lh_ptr, le;
    logic lh_val;
    int tests = 0, fails = 0;
    vec_t vecs [11];

    logic rd_en [3], wr_en [3], emp_en [3], rv [3], tr [3];
    logic [7:0] rd_addr [3], wr_addr [3], emp [3];
    ram_data_t wr_data [3];
    ht_result_t res [3];

    logic s_rd_en, s_wr_en, s_emp_en, s_rv, s_tr, s_h_en, s_h_val;
    logic [7:0] s_rd_addr, s_wr_addr, s_emp, s_h_addr, s_h_ptr;
    ram_data_t s_wr_data;
    ht_result_t s_res;

    data_table_delete_v2_if hif0 ();
    data_table_delete_v2_if hif1 ();
    data_table_delete_v2_if hif2 ();

    always #5 clk = ~clk;

    data_table_delete_v2 #(.RAM_LATENCY(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .task_i(tsk), .task_valid_i(tv && sel == 2'd0), .task_ready_o(tr[0]),
        .rd_data_i(rdata), .rd_addr_o(rd_addr[0]), .rd_en_o(rd_en[0]),
        .wr_addr_o(wr_addr[0]), .wr_data_o(wr_data[0]), .wr_en_o(wr_en[0]),
        .add_empty_ptr_o(emp[0]), .add_empty_ptr_en_o(emp_en[0]), .head_table_if(hif0),
        .result_o(res[0]), .result_valid_o(rv[0]), .result_ready_i(rr && sel == 2'd0));

    data_table_delete_v2 #(.RAM_LATENCY(3), .MATCH_VALUE(1'b1), .MAX_CHAIN(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .task_i(tsk), .task_valid_i(tv && sel == 2'd1), .task_ready_o(tr[1]),
        .rd_data_i(rdata), .rd_addr_o(rd_addr[1]), .rd_en_o(rd_en[1]),
        .wr_addr_o(wr_addr[1]), .wr_data_o(wr_data[1]), .wr_en_o(wr_en[1]),
        .add_empty_ptr_o(emp[1]), .add_empty_ptr_en_o(emp_en[1]), .head_table_if(hif1),
        .result_o(res[1]), .result_valid_o(rv[1]), .result_ready_i(rr && sel == 2'd1));

    data_table_delete_v2 #(.RAM_LATENCY(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .task_i(tsk), .task_valid_i(tv && sel == 2'd2), .task_ready_o(tr[2]),
        .rd_data_i(rdata), .rd_addr_o(rd_addr[2]), .rd_en_o(rd_en[2]),
        .wr_addr_o(wr_addr[2]), .wr_data_o(wr_data[2]), .wr_en_o(wr_en[2]),
        .add_empty_ptr_o(emp[2]), .add_empty_ptr_en_o(emp_en[2]), .head_table_if(hif2),
        .result_o(res[2]), .result_valid_o(rv[2]), .result_ready_i(rr && sel == 2'd2));

    always_comb begin
        s_rd_en = rd_en[sel];
        s_rd_addr = rd_addr[sel];
        s_wr_en = wr_en[sel];
        s_wr_addr = wr_addr[sel];
        s_wr_data = wr_data[sel];
        s_emp_en = emp_en[sel];
        s_emp = emp[sel];
        s_rv = rv[sel];
        s_tr = tr[sel];
        s_res = res[sel];
        s_h_en = sel == 2'd1 ? hif1.wr_en : sel == 2'd2 ? hif2.wr_en : hif0.wr_en;
        s_h_addr = sel == 2'd1 ? hif1.wr_addr : sel == 2'd2 ? hif2.wr_addr : hif0.wr_addr;
        s_h_ptr = sel == 2'd1 ? hif1.wr_data_ptr : sel == 2'd2 ? hif2.wr_data_ptr : hif0.wr_data_ptr;
        s_h_val = sel == 2'd1 ? hif1.wr_data_ptr_val : sel == 2'd2 ? hif2.wr_data_ptr_val : hif0.wr_data_ptr_val;
        rdata = mem[sel == 2'd1 ? pa[2] : sel == 2'd2 ? pa[0] : pa[1]];
    end

    // RAM model with per-configuration read latency, plus write/strobe monitors
    always @(posedge clk) begin
        if (s_wr_en) mem[s_wr_addr] <= s_wr_data;
        else if (bd_en) mem[bd_addr] <= bd_data;
        pa[0] <= s_rd_addr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        if (s_rd_en) rd_cnt <= rd_cnt + 1;
        if (s_wr_en) wr_cnt <= wr_cnt + 1;
        if (s_h_en) begin
            h_cnt <= h_cnt + 1;
            lh_addr <= s_h_addr;
            lh_ptr <= s_h_ptr;
            lh_val <= s_h_val;
        end
        if (s_emp_en) begin
            e_cnt <= e_cnt + 1;
            le <= s_emp;
        end
        if ((s_h_en && (s_wr_en || s_emp_en)) || (s_emp_en && !s_wr_en)) viol <= viol + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bd_write(input logic [7:0] a, input ram_data_t d);
        bd_en = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(posedge clk);
        #1;
        bd_en = 1'b0;
    endtask

    task automatic setup_chain(input int kind);
        bd_write(8'd5, N5);
        bd_write(8'd9, N9);
        bd_write(8'd3, N3);
        if (kind == 1) begin
            bd_write(8'd4, N4);
            bd_write(8'd7, N7);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        string p;
        int r0, h0, e0, lat;
        logic ok;
        logic [7:0] bkt;
        ht_result_t held;
        p = $sformatf("v%0d", id);
        bkt = 8'h20 + 8'(id);
        setup_chain(v.kind);
        sel = 2'(v.sel);
        #1;
        r0 = rd_cnt;
        h0 = h_cnt;
        e0 = e_cnt;
        chk({p, " ready_idle"}, s_tr, 1);
        tsk = '{cmd: '{key: v.key, value: v.value}, bucket: bkt, head_ptr: v.head, head_ptr_val: v.hval};
        tv = 1'b1;
        @(posedge clk);
        #1;
        tv = 1'b0;
        lat = 1;
        while (!s_rv && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({p, " latency"}, lat, v.lat);
        chk({p, " rescode"}, s_res.rescode, v.code);
        chk({p, " key_echo"}, s_res.cmd.key, v.key);
        chk({p, " bucket_echo"}, s_res.bucket, bkt);
        chk({p, " found_value"}, s_res.found_value, 0);
        held = s_res;
        if (v.hold > 0) begin
            ok = 1'b1;
            repeat (v.hold) begin
                @(posedge clk);
                #1;
                if (s_rv !== 1'b1 || s_res !== held || s_tr !== 1'b0) ok = 1'b0;
            end
            chk({p, " hold_stable"}, ok, 1);
        end
        rr = 1'b1;
        @(posedge clk);
        #1;
        rr = 1'b0;
        chk({p, " ready_after"}, s_tr, 1);
        chk({p, " valid_after"}, s_rv, 0);
        chk({p, " reads"}, rd_cnt - r0, v.reads);
        chk({p, " head_writes"}, h_cnt - h0, v.hw);
        if (v.hw) begin
            chk({p, " head_addr"}, lh_addr, bkt);
            chk({p, " head_ptr"}, lh_ptr, v.hptr);
            chk({p, " head_val"}, lh_val, v.hpval);
        end
        chk({p, " empty_strobes"}, e_cnt - e0, v.emp >= 0);
        if (v.emp >= 0) chk({p, " empty_ptr"}, le, v.emp);
        chk({p, " mem5"}, mem[5], v.m5);
        chk({p, " mem9"}, mem[9], v.m9);
        chk({p, " mem3"}, mem[3], v.m3);
    endtask

    initial begin
        int w0, r0;
        vecs[0]  = '{0, 0, 16'h0011, 16'h0000, 8'd5, 1'b0, 0,  DELETE_NOT_SUCCESS_NO_ENTRY,  0, 1,  1'b0, 8'd0, 1'b0, -1, N5,  N9,  N3};
        vecs[1]  = '{0, 0, 16'h0105, 16'hBEEF, 8'd5, 1'b1, 10, DELETE_SUCCESS,               1, 6,  1'b1, 8'd9, 1'b1, 5,  RZ,  N9,  N3};
        vecs[2]  = '{0, 0, 16'h0109, 16'h0000, 8'd5, 1'b1, 0,  DELETE_SUCCESS,               2, 9,  1'b0, 8'd0, 1'b0, 9,  N53, RZ,  N3};
        vecs[3]  = '{0, 0, 16'h0103, 16'h0000, 8'd5, 1'b1, 0,  DELETE_SUCCESS,               3, 12, 1'b0, 8'd0, 1'b0, 3,  N5,  N9T, RZ};
        vecs[4]  = '{0, 0, 16'h0777, 16'h0000, 8'd5, 1'b1, 0,  DELETE_NOT_SUCCESS_NO_ENTRY,  3, 10, 1'b0, 8'd0, 1'b0, -1, N5,  N9,  N3};
        vecs[5]  = '{1, 0, 16'h0105, 16'hBEEF, 8'd5, 1'b1, 0,  DELETE_NOT_SUCCESS_NO_ENTRY,  3, 13, 1'b0, 8'd0, 1'b0, -1, N5,  N9,  N3};
        vecs[6]  = '{1, 0, 16'h0109, 16'h5009, 8'd5, 1'b1, 0,  DELETE_SUCCESS,               2, 11, 1'b0, 8'd0, 1'b0, 9,  N53, RZ,  N3};
        vecs[7]  = '{1, 0, 16'h0105, 16'h5005, 8'd5, 1'b1, 0,  DELETE_SUCCESS,               1, 7,  1'b1, 8'd9, 1'b1, 5,  RZ,  N9,  N3};
        vecs[8]  = '{1, 1, 16'h0999, 16'h0000, 8'd4, 1'b1, 0,  DELETE_NOT_SUCCESS_CHAIN_ERR, 4, 17, 1'b0, 8'd0, 1'b0, -1, N5,  N9,  N3};
        vecs[9]  = '{2, 0, 16'h0105, 16'h0000, 8'd5, 1'b1, 0,  DELETE_SUCCESS,               1, 5,  1'b1, 8'd9, 1'b1, 5,  RZ,  N9,  N3};
        vecs[10] = '{2, 0, 16'h0103, 16'h0000, 8'd5, 1'b1, 0,  DELETE_SUCCESS,               3, 9,  1'b0, 8'd0, 1'b0, 3,  N5,  N9T, RZ};

        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", s_tr, 1);
        chk("reset strobes", {s_rd_en, s_wr_en, s_emp_en, s_h_en, s_rv}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        // reset while a read is outstanding
        setup_chain(0);
        sel = 2'd0;
        tsk = '{cmd: '{key: 16'h0109, value: 16'h0}, bucket: 8'h40, head_ptr: 8'd5, head_ptr_val: 1'b1};
        tv = 1'b1;
        @(posedge clk);
        #1;
        tv = 1'b0;
        chk("midrst rd_strobe", s_rd_en, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst strobes", {s_rd_en, s_wr_en, s_emp_en, s_h_en, s_rv}, 0);
        chk("midrst idle", s_tr, 1);
        w0 = wr_cnt + h_cnt + e_cnt;
        r0 = rd_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midrst no_writes", wr_cnt + h_cnt + e_cnt - w0, 0);
        chk("midrst no_reads", rd_cnt - r0, 0);
        chk("midrst still_idle", s_tr, 1);
        run_vec(vecs[1], 11);

        chk("single_write_strobe", viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_table_delete_v2.md
Name: data_table_delete_v2

Overview:
Delete engine for the hash-table data RAM, the successor to the current delete FSM. It walks a bucket chain from its head pointer, unlinks the matching node and clears that node's RAM word. It returns the node's address to the empty-pointer store and reports a result code. New in this generation:
- parametrised RAM latency, address width and match mode (key only, or key+value);
- a chain-length guard against corrupted (cyclic) chains;
- the previous node's full word is kept, so a middle/tail unlink writes back that word unchanged except for its next pointer.

Parameters:
RAM_LATENCY, 2, read latency of data RAM in cycles (>=1)
A_WIDTH, TABLE_ADDR_WIDTH, data RAM address width
MATCH_VALUE, 0, 0: match on key only; 1: match on key and value
MAX_CHAIN, 2**A_WIDTH, maximum nodes visited before aborting with chain error

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
task_i  in  ht_pdata_t  delete task: cmd, bucket, head_ptr, head_ptr_val
task_valid_i  in  1  task valid
task_ready_o  out  1  high only in IDLE
rd_data_i  in  ram_data_t  RAM read data, valid RAM_LATENCY cycles after rd_en_o
rd_addr_o  out  A_WIDTH  RAM read address
rd_en_o  out  1  one-cycle read strobe per node
wr_addr_o  out  A_WIDTH  RAM write address
wr_data_o  out  ram_data_t  RAM write data
wr_en_o  out  1  one-cycle write strobe
add_empty_ptr_o  out  A_WIDTH  freed address
add_empty_ptr_en_o  out  1  one-cycle strobe
head_table_if  master  head_table_if  bucket head update (wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en)
result_o  out  ht_result_t  cmd, bucket, found_value='0, rescode
result_valid_o  out  1  result valid
result_ready_i  in  1  result accepted

Behaviour:
- Reset: FSM to IDLE_S. All strobes (rd_en_o, wr_en_o, add_empty_ptr_en_o, head_table_if.wr_en, result_valid_o) are 0. Internal registers (addr, prev addr, prev word, node counter, locked task) are 0. task_ready_o=1.
- Reset asserted mid-operation: abort immediately, with no partial write completed after reset. The bench must not rely on chain consistency after a mid-op reset.
- Match: key_match = (rd.key==task.cmd.key) && (!MATCH_VALUE || rd.value==task.cmd.value). Tail = !rd.next_ptr_val.
- Each state below issues exactly one strobe on its entry cycle.
- IDLE_S:
  - task accepted when task_valid_i && task_ready_o; lock the task;
  - if head_ptr_val=0 go to NO_ENTRY_S, else go to READ_S with cur_addr=head_ptr, is_head=1, cnt=0.
- READ_S:
  - rd_en_o=1 with rd_addr_o=cur_addr on the first cycle only;
  - wait RAM_LATENCY cycles (rd_data_val_helper), then capture the word into cur_word;
  - match and is_head: go to UNLINK_HEAD_S;
  - match and !is_head: go to UNLINK_PREV_S;
  - no match and tail: go to NO_ENTRY_S;
  - no match and cnt+1==MAX_CHAIN: go to CHAIN_ERR_S;
  - otherwise: prev_addr=cur_addr, prev_word=cur_word, cur_addr=next_ptr, is_head=0, cnt++, re-enter READ_S. Read strobe spacing is RAM_LATENCY+1 cycles.
- UNLINK_HEAD_S: head_table_if write of bucket with {cur_word.next_ptr, next_ptr_val}. A tail head therefore writes val=0. Then go to CLEAR_S.
- UNLINK_PREV_S: wr_en_o at prev_addr with prev_word, next_ptr/next_ptr_val replaced by cur_word's. A tail yields val=0. Then go to CLEAR_S.
- CLEAR_S: wr_en_o at cur_addr with wr_data_o='0. In the same cycle add_empty_ptr_en_o=1 with add_empty_ptr_o=cur_addr. Then go to REPORT_S with rescode DELETE_SUCCESS.
- NO_ENTRY_S: rescode DELETE_NOT_SUCCESS_NO_ENTRY. CHAIN_ERR_S: rescode DELETE_NOT_SUCCESS_CHAIN_ERR. Neither state writes anything.
- Result: result_valid_o is held with stable result_o until result_ready_i, then return to IDLE_S. A new task is accepted no earlier than the cycle after the handshake.
- No two write strobes are ever active in the same cycle, except the CLEAR_S write plus its empty-pointer strobe.
- Latency, head hit with ready held high: accept → rd_en at +1 → data at +1+RAM_LATENCY → head write → clear → result valid at +4+RAM_LATENCY.
- The counter is $clog2(MAX_CHAIN+1) bits wide and never wraps.

Decomposition:
- Package hash_table:
  - add DELETE_NOT_SUCCESS_CHAIN_ERR to the rescode enum;
  - ram_data_t and ht_pdata_t are unchanged.
- The state enum is local to the module.
- Reuse the existing rd_data_val_helper sub-module (RAM_LATENCY parameter) for read-data valid. No other sub-module.

Test Plan:
- head_ptr_val=0, key 0x11 → no RAM access; result DELETE_NOT_SUCCESS_NO_ENTRY one cycle after accept.
- Chain 5→9→3, delete the key at node 5 → head write {9, val=1}; RAM[5]='0; empty ptr 5; DELETE_SUCCESS; RAM[9] untouched.
- Same chain, delete the key at node 9 → write RAM[5] with next_ptr=3 and key/value unchanged; clear RAM[9]; empty ptr 9.
- Same chain, delete the key at node 3 (tail) → RAM[9].next_ptr_val=0; clear RAM[3]; key absent from the chain → NO_ENTRY after 3 reads.
- MATCH_VALUE=1, key hit but value differs at every node → NO_ENTRY; cyclic chain 4→7→4 with MAX_CHAIN=4 → CHAIN_ERR after exactly 4 reads.
- Sweep RAM_LATENCY=1,3. Hold result_ready_i low for 10 cycles → result stable, task_ready_o=0. Reset asserted mid-READ_S → all strobes 0, IDLE.
